// File: rtl/sender_arbiter.sv
// Grants exclusive use of the shared UART element sender to one of N_REQ requesters,
// with round-robin fairness, drain of an in-flight element and owner-inactivity timeout.
module sender_arbiter #(
  parameter int N_REQ        = 3,
  parameter int IDLE_TIMEOUT = 100_000_000,
  parameter int DATA_W       = 16,
  localparam int IDX_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int CNT_W       = $clog2(IDLE_TIMEOUT + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_REQ-1:0]                req_lock,
  input  logic [N_REQ-1:0]                req_start,
  input  logic [N_REQ-1:0]                req_is_last_col,
  input  logic [N_REQ-1:0]                req_newline_only,
  input  logic [N_REQ-1:0]                req_id,
  input  logic [N_REQ-1:0][DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_REQ-1:0]                req_done,
  output logic                            snd_start,
  output logic                            snd_is_last_col,
  output logic                            snd_newline_only,
  output logic                            snd_id,
  output logic signed [DATA_W-1:0]        snd_data,
  input  logic                            snd_ready,
  input  logic                            snd_done,
  output logic                            grant_valid,
  output logic [IDX_W-1:0]                grant_idx,
  output logic                            timeout_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic              grant_valid_q;
  logic              in_flight_q, in_flight_d, in_flight_nx;
  logic [N_REQ-1:0]  lockout_q, lockout_d;
  logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic              timeout_err_q, timeout_err_d;
  logic [N_REQ-1:0]  elig;
  logic              fire;

  logic                     lat_is_last_col_p0;
  logic                     lat_newline_only_p0;
  logic                     lat_id_p0;
  logic signed [DATA_W-1:0] lat_data_p0;

  // First eligible index after 'last', wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic [N_REQ-1:0] sh;
    int               idx;
    pick = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      sh  = req >> idx;
      if (sh[0]) pick = IDX_W'(idx);
    end
    return pick;
  endfunction

  assign fire = (state_q == ST_OWN) && req_start[grant_idx_q];
  assign elig = req_lock & ~lockout_q;

  always_comb begin
    snd_start        = 1'b0;
    snd_is_last_col  = 1'b0;
    snd_newline_only = 1'b0;
    snd_id           = 1'b0;
    snd_data         = '0;
    req_ready        = '0;
    req_done         = '0;
    if (state_q == ST_OWN) begin
      snd_start                = req_start[grant_idx_q];
      snd_is_last_col          = req_is_last_col[grant_idx_q];
      snd_newline_only         = req_newline_only[grant_idx_q];
      snd_id                   = req_id[grant_idx_q];
      snd_data                 = req_data[grant_idx_q];
      req_ready[grant_idx_q]   = snd_ready;
      req_done[grant_idx_q]    = snd_done;
    end else if (state_q == ST_DRAIN) begin
      snd_is_last_col          = lat_is_last_col_p0;
      snd_newline_only         = lat_newline_only_p0;
      snd_id                   = lat_id_p0;
      snd_data                 = lat_data_p0;
      req_done[grant_idx_q]    = snd_done;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    last_grant_d  = last_grant_q;
    in_flight_d   = in_flight_q;
    lockout_d     = lockout_q & req_lock;
    idle_cnt_d    = idle_cnt_q;
    timeout_err_d = 1'b0;
    in_flight_nx  = req_start[grant_idx_q] | (in_flight_q & ~snd_done);
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d     = ST_OWN;
          grant_idx_d = rr_pick(elig, last_grant_q);
          in_flight_d = 1'b0;
          idle_cnt_d  = '0;
        end
      end
      ST_OWN: begin
        in_flight_d = in_flight_nx;
        if (!req_lock[grant_idx_q]) begin
          // A transfer still outstanding (or launched this cycle) must finish first.
          state_d      = in_flight_nx ? ST_DRAIN : ST_IDLE;
          last_grant_d = grant_idx_q;
          idle_cnt_d   = '0;
        end else if (req_start[grant_idx_q]) begin
          idle_cnt_d = '0;
        end else if (!in_flight_q) begin
          if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
            state_d                = ST_IDLE;
            timeout_err_d          = 1'b1;
            lockout_d[grant_idx_q] = 1'b1;
            last_grant_d           = grant_idx_q;
            in_flight_d            = 1'b0;
            idle_cnt_d             = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (snd_done) begin
          state_d     = ST_IDLE;
          in_flight_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      last_grant_q  <= IDX_W'(N_REQ - 1);
      grant_valid_q <= 1'b0;
      in_flight_q   <= 1'b0;
      lockout_q     <= '0;
      idle_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      last_grant_q  <= last_grant_d;
      grant_valid_q <= (state_d != ST_IDLE);
      in_flight_q   <= in_flight_d;
      lockout_q     <= lockout_d;
      idle_cnt_q    <= idle_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Element fields captured at each accepted start, replayed while draining.
  always_ff @(posedge clk) begin
    if (fire) begin
      lat_is_last_col_p0  <= req_is_last_col[grant_idx_q];
      lat_newline_only_p0 <= req_newline_only[grant_idx_q];
      lat_id_p0           <= req_id[grant_idx_q];
      lat_data_p0         <= req_data[grant_idx_q];
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign timeout_err = timeout_err_q;

endmodule
